add_pipe_lanes: RTL and testbench



---
 rtl/add_pipe_lanes.sv | 109 ++++++++++
 tb/tb_add_pipe_lanes.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe_lanes.sv
// Multi-lane add/subtract pipeline with wrap/saturate modes, per-lane
// overflow flags, valid/ready handshake, global stall and synchronous flush.
module add_pipe_lanes #(
  parameter int unsigned W      = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           mode_i,
  input  logic [LANES*W-1:0]   a_i,
  input  logic [LANES*W-1:0]   b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LANES*W-1:0]   y_o,
  output logic [LANES-1:0]     ovf_o,
  output logic [15:0]          beat_cnt_o
);

  // mode_i[1]: 0 = add, 1 = sub; mode_i[0]: 0 = wrap, 1 = saturate
  logic [LANES*W-1:0] res_y;
  logic [LANES-1:0]   res_ovf;

  logic [STAGES-1:0]  vld_q, vld_d;
  logic [LANES*W-1:0] y_q   [STAGES];
  logic [LANES-1:0]   ovf_q [STAGES];
  logic [15:0]        cnt_q, cnt_d;
  logic               adv;

  logic [W:0]   sum_w, dif_w;
  logic [W-1:0] lane_y;
  logic         lane_ovf;

  // Per-lane arithmetic feeding stage 1
  always_comb begin
    res_y    = '0;
    res_ovf  = '0;
    sum_w    = '0;
    dif_w    = '0;
    lane_y   = '0;
    lane_ovf = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_w = {1'b0, a_i[i*W +: W]} + {1'b0, b_i[i*W +: W]};
      dif_w = {1'b0, a_i[i*W +: W]} - {1'b0, b_i[i*W +: W]};
      if (mode_i[1]) begin
        lane_ovf = dif_w[W];  // borrow out
        lane_y   = dif_w[W-1:0];
      end else begin
        lane_ovf = sum_w[W];  // carry out
        lane_y   = sum_w[W-1:0];
      end
      if (mode_i[0] && lane_ovf) begin
        lane_y = mode_i[1] ? '0 : '1;
      end
      res_y[i*W +: W] = lane_y;
      res_ovf[i]      = lane_ovf;
    end
  end

  // The whole pipe moves together whenever the output slot can drain
  assign adv        = out_ready_i | ~vld_q[STAGES-1];
  assign in_ready_o = adv;

  // Next-state valid bits and delivered-beat counter
  always_comb begin
    vld_d = vld_q;
    if (flush_i) begin
      vld_d = '0;
    end else if (adv) begin
      vld_d[0] = in_valid_i;
      for (int unsigned s = 1; s < STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
      end
    end
    cnt_d = cnt_q + {15'd0, vld_q[STAGES-1] & out_ready_i};
  end

  // Stage registers; data may go stale behind a cleared valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        y_q[s]   <= '0;
        ovf_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (adv) begin
        y_q[0]   <= res_y;
        ovf_q[0] <= res_ovf;
        for (int unsigned s = 1; s < STAGES; s++) begin
          y_q[s]   <= y_q[s-1];
          ovf_q[s] <= ovf_q[s-1];
        end
      end
    end
  end

  assign out_valid_o = vld_q[STAGES-1];
  assign y_o         = y_q[STAGES-1];
  assign ovf_o       = ovf_q[STAGES-1];
  assign beat_cnt_o  = cnt_q;

endmodule

// File: tb/tb_add_pipe_lanes.sv
// Scoreboard bench for add_pipe_lanes: accepted beats push a model result,
// a monitor compares whatever the DUT presents on its output side.
module tb_add_pipe_lanes;
  localparam int unsigned W      = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned STAGES = 2;
  localparam int unsigned DW     = W * LANES;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [DW-1:0]    a, b;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    y;
  logic [LANES-1:0] ovf;
  logic [15:0]      beat_cnt;

  typedef struct packed {
    logic [DW-1:0]    y;
    logic [LANES-1:0] ovf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;

  add_pipe_lanes #(.W(W), .LANES(LANES), .STAGES(STAGES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .mode_i     (mode),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .y_o        (y),
    .ovf_o      (ovf),
    .beat_cnt_o (beat_cnt)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic per lane
  function automatic exp_t model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                 input logic [1:0] m);
    exp_t e;
    int   maxv;
    maxv = (1 << W) - 1;
    e    = '0;
    for (int i = 0; i < LANES; i++) begin
      int x, z, r;
      bit of;
      x = int'(av[i*W +: W]);
      z = int'(bv[i*W +: W]);
      if (!m[1]) begin
        r  = x + z;
        of = (r > maxv);
      end else begin
        r  = x - z;
        of = (r < 0);
      end
      if (of && m[0]) r = m[1] ? 0 : maxv;
      e.y[i*W +: W] = r[W-1:0];
      e.ovf[i]      = of;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus-side tracker: every accepted beat enqueues its expected result
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready && !flush) sb.push_back(model(a, b, mode));
  end

  // Monitor: output must match queue head whenever valid; pop on delivery
  always @(negedge clk) begin
    if (rst_n) begin
      chk("beat_cnt", {48'd0, beat_cnt}, {48'd0, exp_cnt});
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got out_valid=1 expected no beat pending at %0t", $time);
        end else begin
          chk("y", {32'd0, y}, {32'd0, sb[0].y});
          chk("ovf", {60'd0, ovf}, {60'd0, sb[0].ovf});
          if (out_ready) begin
            void'(sb.pop_front());
            exp_cnt++;
          end
        end
      end
      if (flush) sb.delete();
    end
  end

  // Present a beat and hold it until accepted; returns at posedge+1
  task automatic send(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [1:0] m);
    int n;
    bit acc;
    n        = 0;
    acc      = 0;
    a        = av;
    b        = bv;
    mode     = m;
    in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        acc = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Counts negedges until out_valid (cycles of latency after the accept edge)
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [15:0] base;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    mode      = '0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    // Reset and idle
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
    chk("idle_y", {32'd0, y}, 64'd0);
    chk("idle_ovf", {60'd0, ovf}, 64'd0);
    chk("idle_beat_cnt", {48'd0, beat_cnt}, 64'd0);
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // Wrap add with fixed latency
    send({8'h01, 8'h80, 8'hFF, 8'h10}, {8'h01, 8'h80, 8'h02, 8'h20}, 2'b00);
    wait_valid(lat);
    chk("wrap_latency", 64'(lat), 64'(STAGES));
    chk("wrap_y", {32'd0, y}, {32'd0, 32'h02_00_01_30});
    chk("wrap_ovf", {60'd0, ovf}, 64'b0110);
    @(posedge clk);
    #1;
    chk("wrap_beat_cnt", {48'd0, beat_cnt}, 64'd1);

    // Saturating and wrapping subtract / saturating add on lane 0
    send({8'h33, 8'h44, 8'h55, 8'hF0}, {8'h11, 8'h22, 8'h33, 8'h20}, 2'b01);
    wait_valid(lat);
    chk("sat_add_y", {56'd0, y[7:0]}, 64'hFF);
    chk("sat_add_ovf", {63'd0, ovf[0]}, 64'd1);
    @(posedge clk);
    #1;
    send({8'hFF, 8'h00, 8'h80, 8'h05}, {8'h01, 8'h01, 8'h7F, 8'h09}, 2'b11);
    wait_valid(lat);
    chk("sat_sub_y", {56'd0, y[7:0]}, 64'h00);
    chk("sat_sub_ovf", {63'd0, ovf[0]}, 64'd1);
    @(posedge clk);
    #1;
    send({8'hFF, 8'h00, 8'h80, 8'h05}, {8'h01, 8'h01, 8'h7F, 8'h09}, 2'b10);
    wait_valid(lat);
    chk("wrap_sub_y", {56'd0, y[7:0]}, 64'hFC);
    chk("wrap_sub_ovf", {63'd0, ovf[0]}, 64'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // Backpressure: 5 beats with a 4-cycle stall
    base = exp_cnt;
    fork
      begin
        for (int k = 1; k <= 5; k++) send(DW'(k), '0, 2'b00);
      end
      begin
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (out_valid) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_beat_cnt", {48'd0, beat_cnt}, {48'd0, 16'(base + 16'd5)});

    // Flush with two beats in flight and a third presented
    base = exp_cnt;
    send({4{8'h11}}, {4{8'h01}}, 2'b00);
    send({4{8'h22}}, {4{8'h02}}, 2'b00);
    out_ready = 1'b0;
    flush     = 1'b1;
    a         = {4{8'h33}};
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("flush_no_out", {63'd0, out_valid}, 64'd0);
    end
    chk("flush_beat_cnt", {48'd0, beat_cnt}, {48'd0, base});
    @(posedge clk);
    #1;
    send({4{8'h44}}, {4{8'h04}}, 2'b10);
    wait_valid(lat);
    chk("post_flush_latency", 64'(lat), 64'(STAGES));
    @(posedge clk);
    #1;
    wait_drain();

    // Random traffic with random stalls and occasional flush
    for (int n = 0; n < 400; n++) begin
      a         = $urandom;
      b         = $urandom;
      mode      = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset with the pipe full and stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 2'b00;
    repeat (4) begin
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #1;
    chk("pre_rst_full", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_y", {32'd0, y}, 64'd0);
    chk("arst_ovf", {60'd0, ovf}, 64'd0);
    chk("arst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
    sb.delete();
    exp_cnt = '0;
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send({8'h7F, 8'h80, 8'hFE, 8'h01}, {8'h01, 8'h80, 8'h03, 8'h01}, 2'b01);
    wait_valid(lat);
    chk("post_rst_latency", 64'(lat), 64'(STAGES));
    @(posedge clk);
    #1;
    wait_drain();
    chk("post_rst_beat_cnt", {48'd0, beat_cnt}, 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
